dl_skid_buf: RTL and testbench
==============================

Name: dl_skid_buf

Overview:
- Elastic pipeline stage for the pipeline datapath.
- Sits between two dl_reg-style pipeline registers. It replaces a bare register where the downstream stage can stall.
- Provides a valid/ready handshake, registered output data and a registered upstream ready.
- Holds one extra skid entry, so full throughput (1 transfer/cycle) is kept with no combinational ready path from downstream to upstream.

Parameters:
NUM_BITS, 32, width of the data payload in bits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream data valid
in_data  input  NUM_BITS  upstream payload
in_ready  output  1  stage can accept; driven directly from a flop
out_valid  output  1  downstream data valid; driven directly from a flop
out_data  output  NUM_BITS  downstream payload; driven directly from a flop
out_ready  input  1  downstream accepts

Behaviour:
- One clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset (rst_n=0, asserted at any time, including mid-transfer):
  - main_valid=0, skid_valid=0, main_data=0, skid_data=0.
  - Outputs become out_valid=0, out_data=0, in_ready=1 immediately (asynchronously).
- Handshake definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Output mapping:
  - out_valid = main_valid; out_data = main_data; in_ready = ~skid_valid.
  - All three are flop outputs.
- Latency: data accepted in cycle N appears on out_data/out_valid in cycle N+1.
- Ordering: strict FIFO order; no drop, no duplication.
- States and transitions at posedge clk, when flush=0:
  - EMPTY (main=0, skid=0):
    - in_fire: main<=in_data → ONE.
    - Otherwise: stay EMPTY.
  - ONE (main=1, skid=0):
    - in_fire & out_fire: main<=in_data → ONE.
    - in_fire & ~out_ready: skid<=in_data → FULL.
    - ~in_fire & out_fire: → EMPTY.
    - Otherwise: hold.
  - FULL (main=1, skid=1), in_ready=0:
    - out_fire: main<=skid_data, skid cleared → ONE.
    - Otherwise: hold both entries.
- No combinational path from out_ready to in_ready. in_ready drops the cycle after the skid fills; the skid absorbs the one word in flight.
- Upstream contract: in_data must be stable while in_valid=1 and in_ready=0. The stage captures only on in_fire.
- Downstream guarantee: out_valid, once high, stays high with out_data stable until out_fire (or flush/reset).
- Flush:
  - flush=1 at a posedge forces main_valid=0 and skid_valid=0 → EMPTY.
  - Flush overrides any simultaneous in_fire; the incoming word is dropped.
  - Any out_fire in that same cycle still counts as consumed by downstream.
  - Data registers may keep stale values; only valids are cleared.
- Illegal state (main=0, skid=1) is unreachable. If it is ever decoded, the stage returns to EMPTY.
- Payload width: no arithmetic; the payload is passed bit-exact.

Optional Feature:
- Macro: DL_SKID_BUF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits: count of cycles with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n=0 and by flush.
  - Increments in the cycle after the stall condition (registered).
- Not defined:
  - Port and counter logic are absent.
  - Functional behaviour of all other ports is identical.

Test Plan:
- Reset then stream: rst_n low 2 cycles, release; in_valid=1 with in_data=1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 on cycles N+1..N+4, out_valid continuous, in_ready never drops.
- Backpressure fill: stream 0xA,0xB,0xC with out_ready=0 from cycle 1 → out_data holds 0xA, skid holds 0xB, in_ready=0 the cycle after 0xB is accepted, 0xC is held upstream. Raise out_ready → outputs 0xA,0xB,0xC in order; in_ready=1 again after 0xA drains.
- Simultaneous in/out in ONE: main=0x5, in_data=0x6 with in_valid=1 and out_ready=1 → next cycle out_data=0x6, skid_valid=0, and 0x5 is consumed exactly once.
- Flush while FULL: main=0x11, skid=0x22, assert flush with in_valid=1 and in_data=0x33 → next cycle out_valid=0, in_ready=1, and 0x11/0x22/0x33 never appear on the output.
- Async reset mid-transfer: FULL state, drop rst_n between clock edges → out_valid=0, out_data=0, in_ready=1 before the next posedge.
- DL_SKID_BUF_STALL_CNT_EN: hold out_valid=1 with out_ready=0 for 10 cycles → stall_cnt=10. Force 70000 stall cycles → stall_cnt=16'hFFFF. Flush → stall_cnt=0.

Source files
------------

// File: rtl/dl_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : dl_skid_buf
// Purpose  : Elastic pipeline stage with one skid entry. Holds a main entry
//            (presented downstream) and a skid entry that absorbs the single
//            word in flight when downstream stalls. Keeps one transfer per
//            cycle with no combinational path from out_ready to in_ready.
//            Optional macro DL_SKID_BUF_STALL_CNT_EN adds a saturating
//            16-bit stall counter output (stall_cnt).
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            flush      - synchronous flush, clears both entries
//            in_valid   - upstream data valid
//            in_data    - upstream payload [NUM_BITS-1:0]
//            in_ready   - stage can accept (flop output)
//            out_valid  - downstream data valid (flop output)
//            out_data   - downstream payload (flop output)
//            out_ready  - downstream accepts
//            stall_cnt  - (DL_SKID_BUF_STALL_CNT_EN only) stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module dl_skid_buf #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [NUM_BITS-1:0] out_data,
  input  logic                out_ready
`ifdef DL_SKID_BUF_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  // State encoding is {main_valid, skid_valid}; 2'b01 is the unreachable
  // illegal combination and is caught by the default branch.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic [NUM_BITS-1:0] r_main_data;
  logic [NUM_BITS-1:0] r_skid_data;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_main_load;
  logic                w_main_from_skid;
  logic                w_skid_load;
  logic [NUM_BITS-1:0] w_main_din;

  assign out_valid  = r_state[1];
  assign out_data   = r_main_data;
  assign in_ready   = r_in_ready;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_state[1] & out_ready;
  assign w_main_din = w_main_from_skid ? r_skid_data : in_data;

  // Next-state and load decode
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          // Downstream stalled: the word in flight goes to the skid.
          w_skid_load = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain path is possible.
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
    // Flush wins over any capture; data registers keep stale contents.
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Registered copy of ~skid_valid so in_ready comes straight off a flop.
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_main_load) begin
        r_main_data <= w_main_din;
      end
      if (w_skid_load) begin
        r_skid_data <= in_data;
      end
    end
  end

`ifdef DL_SKID_BUF_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (r_state[1] && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dl_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dl_skid_buf
// Purpose  : Directed self-checking bench for dl_skid_buf (NUM_BITS=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dl_skid_buf;

  localparam int NUM_BITS = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic [NUM_BITS-1:0] in_data = '0;
  logic                in_ready;
  logic                out_valid;
  logic [NUM_BITS-1:0] out_data;
  logic                out_ready = 1'b0;
`ifdef DL_SKID_BUF_STALL_CNT_EN
  logic [15:0]         stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dl_skid_buf #(.NUM_BITS(NUM_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef DL_SKID_BUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset (asserted before the first edge) ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_in_ready",  in_ready,  1);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // ---------------- stream 1..4 with out_ready=1 ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = NUM_BITS'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data,  64'(i));
      chk("stream_ready", in_ready,  1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);

    // ---------------- backpressure fill A,B,C ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    chk("bp_A_data",  out_data, 32'hA);
    chk("bp_A_ready", in_ready, 1);
    in_data = 32'hB;
    tick();
    chk("bp_B_data",  out_data, 32'hA);
    chk("bp_B_ready", in_ready, 0);
    in_data = 32'hC;
    tick();
    chk("bp_hold_data",  out_data, 32'hA);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_B",       out_data, 32'hB);
    chk("bp_drain_ready",   in_ready, 1);
    tick();
    chk("bp_drain_C",       out_data, 32'hC);
    chk("bp_drain_C_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", out_valid, 0);

    // ---------------- simultaneous in/out in ONE ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    chk("sim_main5", out_data, 32'h5);
    in_data   = 32'h6;
    out_ready = 1'b1;
    tick();
    chk("sim_data6",  out_data,  32'h6);
    chk("sim_valid",  out_valid, 1);
    chk("sim_no_skid", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("sim_empty", out_valid, 0);

    // ---------------- flush while FULL ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data   = 32'h22;
    tick();
    chk("fl_full_ready", in_ready, 0);
    chk("fl_full_data",  out_data, 32'h11);
    flush   = 1'b1;
    in_data = 32'h33;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready,  1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_quiet_valid", out_valid, 0);
    end

    // ---------------- async reset mid-transfer ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    tick();
    in_data   = 32'h55;
    tick();
    chk("ar_full_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data",  out_data,  0);
    chk("ar_in_ready",  in_ready,  1);
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h77;
    tick();
    chk("ar_post_data",  out_data,  32'h77);
    chk("ar_post_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar_post_empty", out_valid, 0);

`ifdef DL_SKID_BUF_STALL_CNT_EN
    // ---------------- stall counter ----------------
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_clear0", stall_cnt, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    tick();
    chk("sc_load", stall_cnt, 0);
    in_valid = 1'b0;
    repeat (10) tick();
    chk("sc_ten", stall_cnt, 16'd10);
    repeat (70000) tick();
    chk("sc_sat", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_flush", stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
